// File: rtl/dt_walker.sv
// Table-driven decision-tree walker: one tree level per clock, loadable node table.
// Optional DT_WALK_STATS_EN adds o_depth (internal nodes visited) alongside the result.
module dt_walker #(
  parameter  int N     = 8,
  parameter  int F     = 30,
  parameter  int C     = 1,
  parameter  int NODES = 64,
  parameter  int D     = 8,
  localparam int AW    = $clog2(NODES),
  localparam int FW    = $clog2(F),
  localparam int RW    = 1 + FW + N + 2*AW + C,
  localparam int DW    = $clog2(D + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cfg_we,
  input  logic [AW-1:0] i_cfg_addr,
  input  logic [RW-1:0] i_cfg_wdata,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [F*N-1:0] i_in_features,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [C-1:0]  o_out_cls,
`ifdef DT_WALK_STATS_EN
  output logic [DW-1:0] o_depth,
`endif
  output logic          o_out_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WALK,
    S_DONE
  } state_t;

  localparam logic [RW-1:0] LEAF0 = {1'b1, {(RW-1){1'b0}}};
  localparam logic [FW:0]   FLIM  = (FW+1)'(F);
  localparam logic [DW-1:0] DLIM  = DW'(D);

  state_t r_state;
  state_t w_nxt;

  logic [RW-1:0]  r_tbl [NODES];
  logic [F*N-1:0] r_feat;
  logic [AW-1:0]  r_cur;
  logic [DW-1:0]  r_depth;
  logic [C-1:0]   r_cls;
  logic           r_err;

  logic [RW-1:0]  w_node;
  logic           w_leaf;
  logic [FW-1:0]  w_fidx;
  logic [N-1:0]   w_thr;
  logic [AW-1:0]  w_left;
  logic [AW-1:0]  w_right;
  logic [C-1:0]   w_cls;
  logic [N-1:0]   w_fval;
  logic           w_bad_f;
  logic           w_over;
  logic           w_lt;
  logic           w_accept;
  logic           w_step;
  logic           w_finish;
  logic           w_cfg_ok;

  assign w_node  = r_tbl[r_cur];
  assign w_cls   = w_node[C-1:0];
  assign w_right = w_node[C +: AW];
  assign w_left  = w_node[C+AW +: AW];
  assign w_thr   = w_node[C+2*AW +: N];
  assign w_fidx  = w_node[C+2*AW+N +: FW];
  assign w_leaf  = w_node[RW-1];

  assign w_bad_f  = ({1'b0, w_fidx} >= FLIM);
  assign w_over   = (r_depth == DLIM);
  assign w_lt     = (w_fval < w_thr);
  assign w_cfg_ok = i_cfg_we && (r_state == S_IDLE);

  // Feature mux: select the feature named by the current node.
  always_comb begin
    w_fval = '0;
    for (int i = 0; i < F; i++) begin
      if (w_fidx == FW'(i)) w_fval = r_feat[i*N +: N];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_nxt       = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept = 1'b1;
          w_nxt    = S_WALK;
        end
      end
      S_WALK: begin
        if (w_leaf || w_bad_f || w_over) begin
          w_finish = 1'b1;
          w_nxt    = S_DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Node table: writes only land while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) r_tbl[i] <= LEAF0;
    end else if (w_cfg_ok) begin
      r_tbl[i_cfg_addr] <= i_cfg_wdata;
    end
  end

  // Walk datapath: sample latch, node pointer, depth and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_feat  <= '0;
      r_cur   <= '0;
      r_depth <= '0;
      r_cls   <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_feat  <= i_in_features;
      r_cur   <= '0;
      r_depth <= '0;
    end else if (w_step) begin
      r_cur   <= w_lt ? w_left : w_right;
      r_depth <= r_depth + DW'(1);
    end else if (w_finish) begin
      r_cls <= w_leaf ? w_cls : '0;
      r_err <= ~w_leaf;
    end
  end

  assign o_out_cls = r_cls;
  assign o_out_err = r_err;
`ifdef DT_WALK_STATS_EN
  assign o_depth = r_depth;
`endif

endmodule

// File: tb/tb_dt_walker.sv
// Self-checking bench for dt_walker against a node-table reference walk.
// Covers reset, thresholds, overrun, bad feature index, hold, drops and random trees.
module tb_dt_walker;

  localparam int N     = 8;
  localparam int F     = 30;
  localparam int C     = 1;
  localparam int NODES = 64;
  localparam int D     = 8;
  localparam int AW    = $clog2(NODES);
  localparam int FW    = $clog2(F);
  localparam int RW    = 1 + FW + N + 2*AW + C;
  localparam int DW    = $clog2(D + 2);

  logic          clk;
  logic          rst_n;
  logic          i_cfg_we;
  logic [AW-1:0] i_cfg_addr;
  logic [RW-1:0] i_cfg_wdata;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [F*N-1:0] i_in_features;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [C-1:0]  o_out_cls;
  logic          o_out_err;
  logic [DW-1:0] w_depth;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference table, one field per array
  bit          m_leaf [NODES];
  int unsigned m_fidx [NODES];
  int unsigned m_thr  [NODES];
  int unsigned m_left [NODES];
  int unsigned m_right[NODES];
  int unsigned m_cls  [NODES];

  dt_walker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_addr    (i_cfg_addr),
    .i_cfg_wdata   (i_cfg_wdata),
    .i_in_valid    (i_in_valid),
    .o_in_ready    (o_in_ready),
    .i_in_features (i_in_features),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_cls     (o_out_cls),
`ifdef DT_WALK_STATS_EN
    .o_depth       (w_depth),
`endif
    .o_out_err     (o_out_err)
  );

`ifndef DT_WALK_STATS_EN
  assign w_depth = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    for (int i = 0; i < NODES; i++) begin
      m_leaf[i] = 1'b1; m_fidx[i] = 0; m_thr[i] = 0;
      m_left[i] = 0; m_right[i] = 0; m_cls[i] = 0;
    end
  endtask

  // Walk the reference table; latency is always depth+1.
  task automatic ref_walk(input logic [F*N-1:0] ft, output int cls,
                          output bit err, output int dep);
    int unsigned cur;
    int unsigned fv;
    cur = 0; dep = 0; cls = 0; err = 0;
    forever begin
      if (m_leaf[cur]) begin
        cls = int'(m_cls[cur]); return;
      end
      if (m_fidx[cur] >= F || dep == D) begin
        err = 1; return;
      end
      fv  = int'(ft[m_fidx[cur]*N +: N]);
      cur = (fv < m_thr[cur]) ? m_left[cur] : m_right[cur];
      dep++;
    end
  endtask

  function automatic logic [RW-1:0] pack(input bit leaf, input int unsigned fidx,
      input int unsigned thr, input int unsigned l, input int unsigned r,
      input int unsigned cls);
    logic [FW-1:0] f; logic [N-1:0] t; logic [AW-1:0] a; logic [AW-1:0] b;
    logic [C-1:0] c;
    f = FW'(fidx); t = N'(thr); a = AW'(l); b = AW'(r); c = C'(cls);
    return {leaf, f, t, a, b, c};
  endfunction

  task automatic cfg_write(input int a, input bit leaf, input int unsigned fidx,
      input int unsigned thr, input int unsigned l, input int unsigned r,
      input int unsigned cls);
    @(negedge clk);
    i_cfg_we    = 1'b1;
    i_cfg_addr  = AW'(a);
    i_cfg_wdata = pack(leaf, fidx, thr, l, r, cls);
    @(negedge clk);
    i_cfg_we = 1'b0;
    m_leaf[a] = leaf; m_fidx[a] = fidx; m_thr[a] = thr;
    m_left[a] = l; m_right[a] = r; m_cls[a] = cls;
  endtask

  function automatic logic [F*N-1:0] rand_feats();
    logic [F*N-1:0] v;
    for (int i = 0; i < F; i++) v[i*N +: N] = N'($urandom);
    return v;
  endfunction

  // Present one sample, scribble the inputs after accept, wait for the result.
  task automatic run_sample(input logic [F*N-1:0] ft, output int cls,
      output bit err, output int dep, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!o_in_ready && w < 50) begin
      @(negedge clk); w++;
    end
    i_in_valid    = 1'b1;
    i_in_features = ft;
    @(posedge clk); #1;
    i_in_valid    = 1'b0;
    i_in_features = rand_feats();
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (o_out_valid) begin
        lat = k; break;
      end
    end
    cls = int'(o_out_cls);
    err = o_out_err;
    dep = int'(w_depth);
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (o_in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", o_in_ready);
    end
    total++;
    if (o_out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b want=0", o_out_valid);
    end
    total++;
    if (o_out_cls !== '0) begin
      bad++; $display("FAIL reset_out_cls got=%0d want=0", o_out_cls);
    end
    total++;
    if (o_out_err !== 1'b0) begin
      bad++; $display("FAIL reset_out_err got=%b want=0", o_out_err);
    end
  endtask

  task automatic test_default_leaf();
    int cls, dep, lat; bit err;
    run_sample('0, cls, err, dep, lat);
    total++;
    if (cls !== 0 || err !== 1'b0 || lat !== 1) begin
      bad++;
      $display("FAIL default_leaf got cls=%0d err=%0d lat=%0d want 0 0 1",
               cls, err, lat);
    end
  endtask

  task automatic test_threshold();
    logic [F*N-1:0] ft;
    int cls, dep, lat; bit err;
    cfg_write(0, 0, 3, 49, 1, 2, 0);
    cfg_write(1, 1, 0, 0, 0, 0, 1);
    cfg_write(2, 1, 0, 0, 0, 0, 0);
    ft = rand_feats();
    ft[3*N +: N] = 8'd48;
    run_sample(ft, cls, err, dep, lat);
    total++;
    if (cls !== 1 || err !== 1'b0 || lat !== 2) begin
      bad++;
      $display("FAIL thr_below got cls=%0d err=%0d lat=%0d want 1 0 2",
               cls, err, lat);
    end
    ft[3*N +: N] = 8'd49;
    run_sample(ft, cls, err, dep, lat);
    total++;
    if (cls !== 0 || err !== 1'b0 || lat !== 2) begin
      bad++;
      $display("FAIL thr_equal got cls=%0d err=%0d lat=%0d want 0 0 2",
               cls, err, lat);
    end
  endtask

  task automatic test_hold_drop();
    logic [F*N-1:0] ft;
    int cls, dep, lat, w; bit err;
    ft = '0;
    ft[3*N +: N] = 8'd48;
    @(negedge clk);
    i_in_valid = 1'b1; i_in_features = ft;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    w = 0;
    while (!o_out_valid && w < 20) begin
      @(posedge clk); #1; w++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      i_cfg_we    = (k == 0);
      i_cfg_addr  = AW'(1);
      i_cfg_wdata = pack(1, 0, 0, 0, 0, 0);
      total++;
      if (o_out_valid !== 1'b1 || o_in_ready !== 1'b0 ||
          o_out_cls !== 1'b1 || o_out_err !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d got v=%b rdy=%b cls=%0d err=%b want 1 0 1 0",
                 k, o_out_valid, o_in_ready, o_out_cls, o_out_err);
      end
    end
    @(negedge clk);
    i_cfg_we = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    total++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release got rdy=%b v=%b want 1 0",
               o_in_ready, o_out_valid);
    end
    run_sample(ft, cls, err, dep, lat);
    total++;
    if (cls !== 1 || err !== 1'b0) begin
      bad++;
      $display("FAIL cfg_drop got cls=%0d err=%0d want 1 0", cls, err);
    end
  endtask

  task automatic test_cfg_same_cycle();
    int w;
    @(negedge clk);
    i_cfg_we    = 1'b1;
    i_cfg_addr  = '0;
    i_cfg_wdata = pack(1, 0, 0, 0, 0, 1);
    i_in_valid  = 1'b1;
    i_in_features = '0;
    @(posedge clk); #1;
    i_cfg_we = 1'b0; i_in_valid = 1'b0;
    m_leaf[0] = 1; m_fidx[0] = 0; m_thr[0] = 0;
    m_left[0] = 0; m_right[0] = 0; m_cls[0] = 1;
    w = 0;
    while (!o_out_valid && w < 20) begin
      @(posedge clk); #1; w++;
    end
    total++;
    if (o_out_cls !== 1'b1 || o_out_err !== 1'b0 || w !== 1) begin
      bad++;
      $display("FAIL cfg_same_cycle got cls=%0d err=%b lat=%0d want 1 0 1",
               o_out_cls, o_out_err, w);
    end
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
  endtask

  task automatic test_selfloop();
    int cls, dep, lat; bit err;
    cfg_write(0, 0, 0, 100, 0, 0, 1);
    run_sample(rand_feats(), cls, err, dep, lat);
    total++;
    if (cls !== 0 || err !== 1'b1 || lat !== D + 1) begin
      bad++;
      $display("FAIL selfloop got cls=%0d err=%0d lat=%0d want 0 1 %0d",
               cls, err, lat, D + 1);
    end
`ifdef DT_WALK_STATS_EN
    total++;
    if (dep !== D) begin
      bad++; $display("FAIL selfloop_depth got=%0d want=%0d", dep, D);
    end
`endif
  endtask

  task automatic test_bad_fidx();
    int cls, dep, lat; bit err;
    cfg_write(0, 0, 31, 200, 1, 1, 1);
    run_sample(rand_feats(), cls, err, dep, lat);
    total++;
    if (cls !== 0 || err !== 1'b1 || lat !== 1) begin
      bad++;
      $display("FAIL bad_fidx got cls=%0d err=%0d lat=%0d want 0 1 1",
               cls, err, lat);
    end
`ifdef DT_WALK_STATS_EN
    total++;
    if (dep !== 0) begin
      bad++; $display("FAIL bad_fidx_depth got=%0d want=0", dep);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int t[$];
    bit prev;
    cfg_write(0, 0, 0, 128, 1, 1, 0);
    cfg_write(1, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    i_in_features = '0;
    i_in_valid  = 1'b1;
    i_out_ready = 1'b1;
    prev = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (o_out_valid && !prev) begin
        t.push_back(cyc);
        total++;
        if (o_out_cls !== 1'b1) begin
          bad++; $display("FAIL b2b_cls got=%0d want=1", o_out_cls);
        end
      end
      prev = o_out_valid;
    end
    i_in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 i_out_ready = 1'b0;
    total++;
    if (t.size() < 3) begin
      bad++; $display("FAIL b2b_count got=%0d want>=3", t.size());
    end else begin
      for (int k = 1; k < t.size(); k++) begin
        total++;
        if (t[k] - t[k-1] !== 4) begin
          bad++;
          $display("FAIL b2b_period got=%0d want=4", t[k] - t[k-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    int cls, dep, lat, ecls, edep; bit err, eerr;
    logic [F*N-1:0] ft;
    for (int tr = 0; tr < 8; tr++) begin
      for (int a = 0; a < NODES; a++) begin
        cfg_write(a, ($urandom_range(0, 2) == 0), $urandom_range(0, 31),
                  $urandom_range(0, 255), $urandom_range(0, NODES - 1),
                  $urandom_range(0, NODES - 1), $urandom_range(0, 1));
      end
      for (int s = 0; s < 6; s++) begin
        ft = rand_feats();
        ref_walk(ft, ecls, eerr, edep);
        run_sample(ft, cls, err, dep, lat);
        total++;
        if (cls !== ecls || err !== eerr || lat !== edep + 1) begin
          bad++;
          $display("FAIL rand_%0d_%0d got cls=%0d err=%0d lat=%0d want %0d %0d %0d",
                   tr, s, cls, err, lat, ecls, eerr, edep + 1);
        end
`ifdef DT_WALK_STATS_EN
        total++;
        if (dep !== edep) begin
          bad++;
          $display("FAIL rand_depth_%0d_%0d got=%0d want=%0d", tr, s, dep, edep);
        end
`endif
      end
    end
  endtask

  task automatic test_reset_midwalk();
    int cls, dep, lat; bit err;
    cfg_write(0, 0, 0, 100, 0, 0, 1);
    @(negedge clk);
    i_in_valid = 1'b1; i_in_features = '0;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 ||
        o_out_err !== 1'b0 || o_out_cls !== '0) begin
      bad++;
      $display("FAIL midwalk_reset got v=%b rdy=%b err=%b cls=%0d want 0 1 0 0",
               o_out_valid, o_in_ready, o_out_err, o_out_cls);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(rand_feats(), cls, err, dep, lat);
    total++;
    if (cls !== 0 || err !== 1'b0 || lat !== 1) begin
      bad++;
      $display("FAIL post_reset_table got cls=%0d err=%0d lat=%0d want 0 0 1",
               cls, err, lat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_wdata = '0;
    i_in_valid = 1'b0; i_in_features = '0; i_out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_default_leaf();
    test_threshold();
    test_hold_drop();
    test_cfg_same_cycle();
    test_selfloop();
    test_bad_fidx();
    test_back_to_back();
    test_random();
    test_reset_midwalk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
